// File: rtl/ras_ckpt.sv
// Return address stack with branch checkpoints for misprediction recovery.
// Optional macro RAS_TOS_REPAIR_EN also checkpoints and restores the top entry value.
module ras_ckpt #(
  parameter int RAS_WIDTH = 32,
  parameter int RAS_DEPTH = 8,
  parameter int CKPT_NUM  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        du_jal_push,
  input  logic [RAS_WIDTH-1:0]        du_jal_push_din,
  input  logic                        du_jr31_pop,
  output logic [RAS_WIDTH-1:0]        du_jr31_pop_dout,
  input  logic                        du_ckpt_save,
  input  logic [$clog2(CKPT_NUM)-1:0] du_ckpt_tag,
  input  logic                        cdb_flush,
  input  logic [$clog2(CKPT_NUM)-1:0] cdb_flush_tag,
  output logic                        ras_empty,
  output logic                        ras_full
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] DEPTH_MAX = (AW+1)'(RAS_DEPTH);

  logic [RAS_WIDTH-1:0] mem [RAS_DEPTH];
  logic [AW-1:0]        tosp, tosp_nx;
  logic [AW:0]          depth_counter, depth_nx;
  logic [RAS_WIDTH-1:0] latest_poped_addr, latest_nx;
  logic [AW-1:0]        ckpt_tosp  [CKPT_NUM];
  logic [AW:0]          ckpt_depth [CKPT_NUM];
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [RAS_WIDTH-1:0] mem_wdata;
`ifdef RAS_TOS_REPAIR_EN
  logic [RAS_WIDTH-1:0] ckpt_val [CKPT_NUM];
  logic [RAS_WIDTH-1:0] save_val;
`endif

  assign ras_empty        = (depth_counter == '0);
  assign ras_full         = (depth_counter == DEPTH_MAX);
  assign du_jr31_pop_dout = ras_empty ? latest_poped_addr : mem[tosp];

  // Flush has priority; a push+pop on a non-empty stack replaces the top in place.
  always_comb begin
    tosp_nx   = tosp;
    depth_nx  = depth_counter;
    latest_nx = latest_poped_addr;
    mem_we    = 1'b0;
    mem_waddr = tosp;
    mem_wdata = du_jal_push_din;
    if (cdb_flush) begin
      tosp_nx  = ckpt_tosp[cdb_flush_tag];
      depth_nx = ckpt_depth[cdb_flush_tag];
`ifdef RAS_TOS_REPAIR_EN
      mem_we    = 1'b1;
      mem_waddr = ckpt_tosp[cdb_flush_tag];
      mem_wdata = ckpt_val[cdb_flush_tag];
`endif
    end else if (du_jal_push && du_jr31_pop && !ras_empty) begin
      mem_we    = 1'b1;
      latest_nx = mem[tosp];
    end else if (du_jal_push) begin
      mem_we    = 1'b1;
      mem_waddr = tosp + AW'(1);
      tosp_nx   = tosp + AW'(1);
      if (depth_counter != DEPTH_MAX)
        depth_nx = depth_counter + (AW+1)'(1);
    end else if (du_jr31_pop && !ras_empty) begin
      latest_nx = mem[tosp];
      tosp_nx   = tosp - AW'(1);
      depth_nx  = depth_counter - (AW+1)'(1);
    end
  end

`ifdef RAS_TOS_REPAIR_EN
  // Top value after this cycle's update: a push always leaves din on top.
  assign save_val = du_jal_push ? du_jal_push_din : mem[tosp_nx];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tosp              <= '0;
      depth_counter     <= '0;
      latest_poped_addr <= '0;
      for (int i = 0; i < CKPT_NUM; i++) begin
        ckpt_tosp[i]  <= '0;
        ckpt_depth[i] <= '0;
`ifdef RAS_TOS_REPAIR_EN
        ckpt_val[i]   <= '0;
`endif
      end
    end else begin
      tosp              <= tosp_nx;
      depth_counter     <= depth_nx;
      latest_poped_addr <= latest_nx;
      if (du_ckpt_save && !cdb_flush) begin
        ckpt_tosp[du_ckpt_tag]  <= tosp_nx;
        ckpt_depth[du_ckpt_tag] <= depth_nx;
`ifdef RAS_TOS_REPAIR_EN
        ckpt_val[du_ckpt_tag]   <= save_val;
`endif
      end
    end
  end

  // Stack storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Testbench for ras_ckpt: directed vector table, hand sequences, and a random run
// checked against a circular-array stack model with checkpoints.
module tb_ras_ckpt;

  localparam int W = 32;
  localparam int D = 4;
  localparam int C = 4;
`ifdef RAS_TOS_REPAIR_EN
  localparam bit REPAIR = 1'b1;
`else
  localparam bit REPAIR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         du_jal_push;
  logic [W-1:0] du_jal_push_din;
  logic         du_jr31_pop;
  logic [W-1:0] du_jr31_pop_dout;
  logic         du_ckpt_save;
  logic [1:0]   du_ckpt_tag;
  logic         cdb_flush;
  logic [1:0]   cdb_flush_tag;
  logic         ras_empty;
  logic         ras_full;

  int errors = 0;
  int checks = 0;

  ras_ckpt #(.RAS_WIDTH(W), .RAS_DEPTH(D), .CKPT_NUM(C)) dut (
    .clk(clk), .reset(reset),
    .du_jal_push(du_jal_push), .du_jal_push_din(du_jal_push_din),
    .du_jr31_pop(du_jr31_pop), .du_jr31_pop_dout(du_jr31_pop_dout),
    .du_ckpt_save(du_ckpt_save), .du_ckpt_tag(du_ckpt_tag),
    .cdb_flush(cdb_flush), .cdb_flush_tag(cdb_flush_tag),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       push;
    logic [W-1:0] din;
    logic       pop;
    logic       save;
    logic [1:0] stag;
    logic       flush;
    logic [1:0] ftag;
    logic [W-1:0] exp_dout;
    logic       exp_empty;
    logic       exp_full;
  } vec_t;

  vec_t vecs[$];

  // Reference model: circular array indexed by top, with an occupancy count.
  int           m_top, m_cnt;
  logic [W-1:0] m_mem [D];
  bit           m_known [D];
  logic [W-1:0] m_latest;
  bit           m_latest_known;
  int           s_top [C];
  int           s_cnt [C];
  logic [W-1:0] s_val [C];
  bit           s_known [C];

  task automatic addVec(input string n, input logic p, input logic [W-1:0] d, input logic q,
                        input logic s, input logic [1:0] st, input logic f, input logic [1:0] ft,
                        input logic [W-1:0] ed, input logic ee, input logic ef);
    vec_t v;
    v.name = n; v.push = p; v.din = d; v.pop = q; v.save = s; v.stag = st;
    v.flush = f; v.ftag = ft; v.exp_dout = ed; v.exp_empty = ee; v.exp_full = ef;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic p, input logic [W-1:0] d, input logic q,
                               input logic s, input logic [1:0] st, input logic f, input logic [1:0] ft);
    reset = r; du_jal_push = p; du_jal_push_din = d; du_jr31_pop = q;
    du_ckpt_save = s; du_ckpt_tag = st; cdb_flush = f; cdb_flush_tag = ft;
  endtask

  task automatic compare(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic checkOutput(input string n, input logic [W-1:0] ed, input logic ee, input logic ef,
                             input bit dout_valid);
    if (dout_valid) compare({n, ".dout"}, du_jr31_pop_dout, ed);
    compare({n, ".empty"}, W'(ras_empty), W'(ee));
    compare({n, ".full"}, W'(ras_full), W'(ef));
  endtask

  task automatic modelReset();
    m_top = 0; m_cnt = 0; m_latest = '0; m_latest_known = 1'b1;
    for (int i = 0; i < D; i++) m_known[i] = 1'b0;
    for (int i = 0; i < C; i++) begin
      s_top[i] = 0; s_cnt[i] = 0; s_val[i] = '0; s_known[i] = 1'b1;
    end
  endtask

  task automatic modelStep(input logic r, input logic p, input logic [W-1:0] d, input logic q,
                           input logic s, input logic [1:0] st, input logic f, input logic [1:0] ft);
    if (r) begin
      modelReset();
    end else if (f) begin
      m_top = s_top[ft];
      m_cnt = s_cnt[ft];
      if (REPAIR) begin
        m_mem[m_top] = s_val[ft];
        m_known[m_top] = s_known[ft];
      end
    end else begin
      if (p && q && m_cnt > 0) begin
        m_latest = m_mem[m_top]; m_latest_known = m_known[m_top];
        m_mem[m_top] = d; m_known[m_top] = 1'b1;
      end else if (p) begin
        m_top = (m_top + 1) % D;
        m_mem[m_top] = d; m_known[m_top] = 1'b1;
        if (m_cnt < D) m_cnt = m_cnt + 1;
      end else if (q && m_cnt > 0) begin
        m_latest = m_mem[m_top]; m_latest_known = m_known[m_top];
        m_top = (m_top + D - 1) % D;
        m_cnt = m_cnt - 1;
      end
      if (s) begin
        s_top[st] = m_top; s_cnt[st] = m_cnt;
        s_val[st] = m_mem[m_top]; s_known[st] = m_known[m_top];
      end
    end
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", '0, 1'b1, 1'b0, 1'b1);

    // Fill past capacity, drain past empty, then same-cycle push+pop and checkpoints.
    for (int k = 0; k < 10; k++)
      addVec($sformatf("push%0d", k), 1, W'(k), 0, 0, 0, 0, 0, W'(k), 0, k >= 3);
    addVec("pop1", 0, 0, 1, 0, 0, 0, 0, 32'd8, 0, 0);
    addVec("pop2", 0, 0, 1, 0, 0, 0, 0, 32'd7, 0, 0);
    addVec("pop3", 0, 0, 1, 0, 0, 0, 0, 32'd6, 0, 0);
    addVec("pop4", 0, 0, 1, 0, 0, 0, 0, 32'd6, 1, 0);
    addVec("pop5_empty", 0, 0, 1, 0, 0, 0, 0, 32'd6, 1, 0);
    addVec("pop6_empty", 0, 0, 1, 0, 0, 0, 0, 32'd6, 1, 0);
    addVec("push10", 1, 32'h10, 0, 0, 0, 0, 0, 32'h10, 0, 0);
    addVec("push20", 1, 32'h20, 0, 0, 0, 0, 0, 32'h20, 0, 0);
    addVec("pushpop30", 1, 32'h30, 1, 0, 0, 0, 0, 32'h30, 0, 0);
    addVec("pp_pop1", 0, 0, 1, 0, 0, 0, 0, 32'h10, 0, 0);
    addVec("pp_pop2", 0, 0, 1, 0, 0, 0, 0, 32'h10, 1, 0);
    addVec("pushA_save1", 1, 32'hA, 0, 1, 1, 0, 0, 32'hA, 0, 0);
    addVec("pushB", 1, 32'hB, 0, 0, 0, 0, 0, 32'hB, 0, 0);
    addVec("pushC", 1, 32'hC, 0, 0, 0, 0, 0, 32'hC, 0, 0);
    addVec("flush1", 0, 0, 0, 0, 0, 1, 1, 32'hA, 0, 0);
    addVec("flush1_pop", 0, 0, 1, 0, 0, 0, 0, 32'hA, 1, 0);
    addVec("pushA_save2", 1, 32'hA, 0, 1, 2, 0, 0, 32'hA, 0, 0);
    addVec("popA", 0, 0, 1, 0, 0, 0, 0, 32'hA, 1, 0);
    addVec("pushE", 1, 32'hE, 0, 0, 0, 0, 0, 32'hE, 0, 0);
    addVec("flush2", 0, 0, 0, 0, 0, 1, 2, REPAIR ? 32'hA : 32'hE, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b0, vecs[i].push, vecs[i].din, vecs[i].pop, vecs[i].save,
                    vecs[i].stag, vecs[i].flush, vecs[i].ftag);
      @(posedge clk);
      #1;
      checkOutput(vecs[i].name, vecs[i].exp_dout, vecs[i].exp_empty, vecs[i].exp_full, 1'b1);
    end

    // Reset dominates push/pop/save/flush and clears checkpoint slots.
    applyStimulus(1'b0, 1'b1, 32'h1, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 32'h2, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 32'h3, 1'b1, 1'b1, 2'd3, 1'b1, 2'd3);
    @(posedge clk); #1;
    checkOutput("reset_dominates", '0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3);
    @(posedge clk); #1;
    checkOutput("slot_cleared", '0, 1'b1, 1'b0, 1'b1);

    // Random traffic against the model, with occasional resets.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    modelReset();
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      logic r, p, q, s, f;
      logic [1:0] st, ft;
      logic [W-1:0] d;
      r  = ($urandom_range(0, 59) == 0);
      p  = ($urandom_range(0, 1) == 1);
      q  = ($urandom_range(0, 99) < 45);
      s  = ($urandom_range(0, 4) == 0);
      f  = ($urandom_range(0, 11) == 0);
      st = 2'($urandom_range(0, 3));
      ft = 2'($urandom_range(0, 3));
      d  = $urandom;
      applyStimulus(r, p, d, q, s, st, f, ft);
      modelStep(r, p, d, q, s, st, f, ft);
      @(posedge clk); #1;
      checkOutput($sformatf("rand%0d", n),
                  (m_cnt > 0) ? m_mem[m_top] : m_latest,
                  m_cnt == 0, m_cnt == D,
                  (m_cnt > 0) ? m_known[m_top] : m_latest_known);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ras_ckpt.md
RAS_CKPT -- requirements
Module: ras_ckpt

Interface
REQ-001 SHALL have parameter RAS_WIDTH, default 32, return-address width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 8, stack entries (power of two, >=2).
REQ-003 SHALL have parameter CKPT_NUM, default 4, checkpoint slots (power of two, >=2).
REQ-004 SHALL have port clk  input  1  rising-edge clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port du_jal_push  input  1  push request from dispatch (JAL).
REQ-007 SHALL have port du_jal_push_din  input  RAS_WIDTH  address to push.
REQ-008 SHALL have port du_jr31_pop  input  1  pop request from dispatch (JR $31).
REQ-009 SHALL have port du_jr31_pop_dout  output  RAS_WIDTH  predicted return address.
REQ-010 SHALL have port du_ckpt_save  input  1  save checkpoint at dispatched branch.
REQ-011 SHALL have port du_ckpt_tag  input  clog2(CKPT_NUM)  slot written on save.
REQ-012 SHALL have port cdb_flush  input  1  misprediction recovery request.
REQ-013 SHALL have port cdb_flush_tag  input  clog2(CKPT_NUM)  slot restored on flush.
REQ-014 SHALL have ports ras_empty and ras_full  output  1 each  depth_counter==0 / ==RAS_DEPTH.

Function
REQ-015 SHALL keep TOSP (clog2(RAS_DEPTH) bits, indexes top valid entry), depth_counter (clog2(RAS_DEPTH)+1 bits) and latest_poped_addr.
REQ-016 SHALL drive du_jr31_pop_dout combinationally: mem[TOSP] if depth_counter>0, else latest_poped_addr.
REQ-017 Push only: SHALL write din at TOSP+1 (mod RAS_DEPTH), advance TOSP, depth_counter saturating at RAS_DEPTH.
REQ-018 Push when full: SHALL overwrite the oldest entry by wrap-around; depth_counter stays RAS_DEPTH.
REQ-019 Pop only, non-empty: SHALL load latest_poped_addr with mem[TOSP], TOSP-1 (mod), depth_counter-1.
REQ-020 Pop when empty: SHALL leave TOSP, depth_counter, latest_poped_addr unchanged (dout repeats latest_poped_addr).
REQ-021 Push+pop same cycle, non-empty: SHALL output old top, overwrite mem[TOSP] with din; TOSP/depth unchanged; latest_poped_addr <= old top.
REQ-022 Push+pop same cycle, empty: SHALL behave as push only; dout = latest_poped_addr.
REQ-023 Save: SHALL store post-update TOSP and depth_counter of that cycle into slot du_ckpt_tag at the clock edge.
REQ-024 Flush: SHALL load TOSP and depth_counter from slot cdb_flush_tag at the edge; push, pop and save that cycle are ignored.
REQ-025 Flush restores pointer state only; latest_poped_addr is not restored.
REQ-026 All state updates SHALL occur on the rising clk edge; latency from request to new dout is one cycle.

Reset
REQ-027 On reset SHALL set TOSP=0, depth_counter=0, latest_poped_addr=0, all checkpoint slots to zero; ras_empty=1, ras_full=0, dout=0.
REQ-028 Stack memory SHALL NOT require reset; reset SHALL dominate push, pop, save and flush.

Configuration
REQ-029 Macro RAS_TOS_REPAIR_EN defined: save SHALL also store the post-update top entry value, flush SHALL rewrite mem[restored TOSP] with it.
REQ-030 RAS_TOS_REPAIR_EN undefined: no entry storage in slots; flush restores TOSP and depth_counter only.

Verification (RAS_WIDTH=32, RAS_DEPTH=4, CKPT_NUM=4)
REQ-031 Reset then push 0..9 on 10 cycles -> ras_full=1, mem holds 6,7,8,9, dout=9.
REQ-032 Then pop 6 cycles -> dout 9,8,7,6,6,6; ras_empty=1 after 4th pop.
REQ-033 Push 0x10,0x20, then push 0x30 + pop together -> dout=0x20 that cycle, next dout=0x30, depth 2.
REQ-034 Push 0xA, save tag 1, push 0xB,0xC, flush tag 1 -> depth 1, dout=0xA.
REQ-035 With RAS_TOS_REPAIR_EN: push 0xA, save tag 2, pop, push 0xE, flush tag 2 -> dout=0xA (without macro: 0xE).
REQ-036 Assert reset mid-sequence while push+flush asserted -> all outputs at reset values next cycle.
